// File: rtl/hoop_pass_scorer.sv
// Per-frame hoop pass / rim-hit detector with a saturating 3-digit BCD score.
// Geometry is combinational; all state advances only on an unpaused startOfFrame.
module hoop_pass_scorer #(
  parameter int HOOP_W          = 28,
  parameter int HOOP_H          = 58,
  parameter int RIM_W           = 6,
  parameter int PLAYER_W        = 32,
  parameter int PLAYER_H        = 32,
  parameter int MIN_IN_FRAMES   = 3,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int POINTS          = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        pause,
  input  logic [10:0] hoopTopLeftX,
  input  logic [10:0] hoopTopLeftY,
  input  logic [10:0] playerTopLeftX,
  input  logic [10:0] playerTopLeftY,
  output logic [11:0] score,
  output logic        scorePulse,
  output logic        rimHit,
  output logic        busy
);

  localparam int ICW = $clog2(MIN_IN_FRAMES + 1);
  localparam int CDW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [ICW-1:0] IN_MIN  = ICW'(MIN_IN_FRAMES);
  localparam logic [CDW-1:0] CD_LAST = CDW'(COOLDOWN_FRAMES - 1);
  localparam logic signed [11:0] HW  = 12'(HOOP_W);
  localparam logic signed [11:0] HH  = 12'(HOOP_H);
  localparam logic signed [11:0] RW  = 12'(RIM_W);
  localparam logic signed [11:0] PHW = 12'(PLAYER_W / 2);
  localparam logic signed [11:0] PHH = 12'(PLAYER_H / 2);

  typedef enum logic [1:0] {IDLE, INSIDE, COOLDOWN} state_t;

  state_t             state;
  logic [ICW-1:0]     inCnt;
  logic [CDW-1:0]     cdCnt;
  logic signed [11:0] lastHy;
  logic               lastValid;

  logic signed [11:0] hx, hy, cx, cy;
  logic               inBox, inOpen, onRim, respawn;

  // Sign-extend to 12 bits so the box edges cannot overflow near the screen limits.
  assign hx = {hoopTopLeftX[10], hoopTopLeftX};
  assign hy = {hoopTopLeftY[10], hoopTopLeftY};
  assign cx = {playerTopLeftX[10], playerTopLeftX} + PHW;
  assign cy = {playerTopLeftY[10], playerTopLeftY} + PHH;

  assign inBox   = (cx >= hx) && (cx < hx + HW) && (cy >= hy) && (cy < hy + HH);
  assign inOpen  = inBox && (cx >= hx + RW) && (cx < hx + HW - RW);
  assign onRim   = inBox && !inOpen;
  // lastValid stops the first frame after reset from comparing against a stale 0.
  assign respawn = lastValid && (hy < lastHy);

  logic [11:0] scoreAdd;
  logic [4:0]  dsum;
  logic        carry;

  always_comb begin
    carry    = 1'b0;
    dsum     = 5'd0;
    scoreAdd = score;
    for (int i = 0; i < 3; i++) begin
      dsum = {1'b0, score[i*4 +: 4]} + ((i == 0) ? 5'(POINTS) : {4'b0, carry});
      if (dsum > 5'd9) begin
        scoreAdd[i*4 +: 4] = 4'(dsum - 5'd10);
        carry              = 1'b1;
      end else begin
        scoreAdd[i*4 +: 4] = dsum[3:0];
        carry              = 1'b0;
      end
    end
    if (carry) scoreAdd = 12'h999;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state      <= IDLE;
      inCnt      <= '0;
      cdCnt      <= '0;
      lastHy     <= '0;
      lastValid  <= 1'b0;
      score      <= '0;
      scorePulse <= 1'b0;
      rimHit     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      scorePulse <= 1'b0;
      rimHit     <= 1'b0;
      if (startOfFrame && !pause) begin
        lastHy    <= hy;
        lastValid <= 1'b1;
        if (respawn) begin
          state <= IDLE;
          busy  <= 1'b0;
          inCnt <= '0;
          cdCnt <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (onRim) begin
                rimHit <= 1'b1;
                state  <= COOLDOWN;
                busy   <= 1'b1;
                cdCnt  <= '0;
              end else if (inOpen) begin
                state <= INSIDE;
                busy  <= 1'b1;
                inCnt <= ICW'(1);
              end
            end
            INSIDE: begin
              if (onRim) begin
                rimHit <= 1'b1;
                state  <= COOLDOWN;
                inCnt  <= '0;
                cdCnt  <= '0;
              end else if (inOpen) begin
                if (inCnt < IN_MIN) inCnt <= inCnt + 1'b1;
              end else if (inCnt >= IN_MIN) begin
                scorePulse <= 1'b1;
                score      <= scoreAdd;
                state      <= COOLDOWN;
                inCnt      <= '0;
                cdCnt      <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                inCnt <= '0;
              end
            end
            COOLDOWN: begin
              if (cdCnt == CD_LAST) begin
                state <= IDLE;
                busy  <= 1'b0;
                cdCnt <= '0;
              end else begin
                cdCnt <= cdCnt + 1'b1;
              end
            end
            default: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_hoop_pass_scorer.sv
// Directed bench: default-parameter scorer plus a fast POINTS=7 instance for BCD carry/saturation.
module tb_hoop_pass_scorer;
  logic        clk = 1'b0, resetN = 1'b0, sof = 1'b0, sof2 = 1'b0, pause = 1'b0;
  logic [10:0] hx, hy, px, py;
  logic [11:0] score, score2;
  logic        sp, rh, busy, sp2, rh2, busy2;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  hoop_pass_scorer dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .pause(pause),
    .hoopTopLeftX(hx), .hoopTopLeftY(hy), .playerTopLeftX(px), .playerTopLeftY(py),
    .score(score), .scorePulse(sp), .rimHit(rh), .busy(busy)
  );

  hoop_pass_scorer #(.POINTS(7), .MIN_IN_FRAMES(1), .COOLDOWN_FRAMES(2)) dut2 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof2), .pause(pause),
    .hoopTopLeftX(hx), .hoopTopLeftY(hy), .playerTopLeftX(px), .playerTopLeftY(py),
    .score(score2), .scorePulse(sp2), .rimHit(rh2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Strobe raised at a negedge; outputs sampled at the following negedge.
  task automatic frame();
    @(negedge clk) sof = 1'b1;
    @(negedge clk) sof = 1'b0;
  endtask

  task automatic frame2();
    @(negedge clk) sof2 = 1'b1;
    @(negedge clk) sof2 = 1'b0;
  endtask

  task automatic setp(input int cx, input int cy);
    px = 11'(cx - 16);
    py = 11'(cy - 16);
  endtask

  // One full pass on dut2 (MIN_IN=1, cooldown=2); p is the pulse after the exit strobe.
  task automatic pass2(output logic p);
    setp(113, 220); frame2();
    setp(113, 300); frame2();
    p = sp2;
    frame2(); frame2();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic p;
    int   n;
    hx = 11'd100; hy = 11'd200; px = '0; py = '0;
    repeat (2) @(negedge clk);
    chk("rst_score", score, 12'h000);
    chk("rst_busy", busy, 12'd0);
    chk("rst_sp", sp, 12'd0);
    chk("rst_rh", rh, 12'd0);
    chk("rst_score2", score2, 12'h000);
    resetN = 1'b1;

    // clean pass: 4 frames in the opening, exit below
    setp(113, 220); frame();
    chk("t1_busy_in", busy, 12'd1);
    repeat (3) frame();
    chk("t1_no_early", sp, 12'd0);
    setp(113, 300); frame();
    chk("t1_sp", sp, 12'd1);
    chk("t1_score", score, 12'h001);
    chk("t1_busy_cd", busy, 12'd1);
    @(negedge clk);
    chk("t1_sp_1cyc", sp, 12'd0);
    px = '0; py = '0;
    repeat (29) frame();
    chk("t1_cd29", busy, 12'd1);
    frame();
    chk("t1_cd30", busy, 12'd0);

    // too short inside the opening
    setp(113, 220); frame(); frame();
    setp(113, 300); frame();
    chk("t2_sp", sp, 12'd0);
    chk("t2_score", score, 12'h001);
    chk("t2_idle", busy, 12'd0);

    // rim clip from IDLE; busy must cover exactly 30 strobes
    setp(102, 220); frame();
    chk("t3_rh", rh, 12'd1);
    chk("t3_sp", sp, 12'd0);
    chk("t3_busy", busy, 12'd1);
    @(negedge clk);
    chk("t3_rh_1cyc", rh, 12'd0);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      frame();
      if (busy) n++;
      else break;
    end
    chk("t3_busy_len", 12'(n), 12'd30);
    chk("t3_score", score, 12'h001);

    // no strobe, no action
    setp(113, 220);
    repeat (6) @(negedge clk);
    chk("nostrobe_busy", busy, 12'd0);

    // respawn while INSIDE beats the pending score
    frame(); frame(); frame();
    chk("t5_inside", busy, 12'd1);
    hy = 11'(-58); px = '0; py = '0; frame();
    chk("t5_resp_sp", sp, 12'd0);
    chk("t5_resp_idle", busy, 12'd0);
    chk("t5_resp_score", score, 12'h001);
    hy = 11'd200;

    // pause holds INSIDE across 10 lost strobes, then scoring resumes
    setp(113, 220); frame(); frame(); frame();
    pause = 1'b1;
    setp(113, 300);
    for (int i = 0; i < 10; i++) begin
      frame();
      chk("t5_pause_sp", sp, 12'd0);
      chk("t5_pause_busy", busy, 12'd1);
    end
    chk("t5_pause_score", score, 12'h001);
    pause = 1'b0;
    frame();
    chk("t5_resume_sp", sp, 12'd1);
    chk("t5_resume_score", score, 12'h002);

    // dut2 to 042, left in COOLDOWN, then a 1-cycle reset
    for (int i = 0; i < 5; i++) pass2(p);
    setp(113, 220); frame2();
    setp(113, 300); frame2();
    chk("t6_score42", score2, 12'h042);
    chk("t6_busy2", busy2, 12'd1);
    @(negedge clk) resetN = 1'b0;
    @(negedge clk) resetN = 1'b1;
    chk("t6_rst_score2", score2, 12'h000);
    chk("t6_rst_busy2", busy2, 12'd0);
    chk("t6_rst_pulse2", {sp2, rh2}, 12'd0);
    chk("t6_rst_score", score, 12'h000);
    chk("t6_rst_busy", busy, 12'd0);

    // BCD carries and saturation with POINTS=7
    pass2(p); pass2(p);
    chk("bcd_014", score2, 12'h014);
    for (int i = 0; i < 13; i++) pass2(p);
    chk("bcd_105", score2, 12'h105);
    for (int i = 0; i < 127; i++) pass2(p);
    chk("bcd_994", score2, 12'h994);
    pass2(p);
    chk("sat_pulse", p, 12'd1);
    chk("sat_999", score2, 12'h999);
    pass2(p);
    chk("sat_hold_pulse", p, 12'd1);
    chk("sat_hold_999", score2, 12'h999);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
